// File: rtl/sub_serial_param_if.sv
// Handshake bundle for the chunk-serial subtractor.
// Carries OVF only when SUB_SERIAL_OVF_EN is defined.
interface sub_serial_param_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             B_out;
`ifdef SUB_SERIAL_OVF_EN
  logic             OVF;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, B_out, OVF
  );
  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, B_out, OVF
  );
`else
  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, B_out
  );
  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, B_out
  );
`endif
endinterface

// File: rtl/sub_serial_param.sv
// Chunk-serial subtractor: Diff = A - B - Bin, CHUNK bits per clock.
// SUB_SERIAL_OVF_EN adds a registered signed-overflow flag (OVF).
module sub_serial_param #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic            clk,
  input  logic            rst,
  sub_serial_param_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow;
  logic             bout_q;
  logic             rdy;
  logic             accept;
  logic             last;
  logic [CHUNK:0]   sl;

  assign accept = bus.in_valid & rdy;
  assign last   = (state == BUSY) && (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = BUSY;
      BUSY: if (last) state_nx = DONE;
      DONE: begin
        if (accept)             state_nx = BUSY;
        else if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdy = (state == IDLE) |
          ((state == DONE) & bus.out_ready);
    bus.in_ready  = rdy;
    bus.out_valid = (state == DONE);
  end

  // One slice with a CHUNK+1 bit result; the top bit is the borrow.
  always_comb begin
    sl = {1'b0, a_q[idx*CHUNK +: CHUNK]}
       - {1'b0, b_q[idx*CHUNK +: CHUNK]}
       - (CHUNK+1)'(borrow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      a_q    <= bus.A;
      b_q    <= bus.B;
      borrow <= bus.Bin;
      idx    <= '0;
    end else if (state == BUSY) begin
      diff_q[idx*CHUNK +: CHUNK] <= sl[CHUNK-1:0];
      borrow <= sl[CHUNK];
      idx    <= idx + 1'b1;
      if (last) bout_q <= sl[CHUNK];
    end
  end

  assign bus.Diff  = diff_q;
  assign bus.B_out = bout_q;

`ifdef SUB_SERIAL_OVF_EN
  logic ovf_q;

  // Operands differ in sign and the result sign differs from A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf_q <= 1'b0;
    else if (last) ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                          & (sl[CHUNK-1] ^ a_q[WIDTH-1]);
  end

  assign bus.OVF = ovf_q;
`endif
endmodule

// File: tb/tb_sub_serial_param.sv
// Bench for sub_serial_param: four CHUNK variants driven in lockstep.
// OVF is checked when SUB_SERIAL_OVF_EN is defined.
module tb_sub_serial_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;

  int checks = 0;
  int errors = 0;

  localparam int NCH [4] = '{2, 4, 1, 32};

  always #5 clk = ~clk;

  sub_serial_param_if #(.WIDTH(32)) b16 ();
  sub_serial_param_if #(.WIDTH(32)) b8 ();
  sub_serial_param_if #(.WIDTH(32)) b32 ();
  sub_serial_param_if #(.WIDTH(32)) b1 ();

  assign b16.in_valid = in_valid;
  assign b16.out_ready = out_ready;
  assign b16.A = A;
  assign b16.B = B;
  assign b16.Bin = Bin;
  assign b8.in_valid = in_valid;
  assign b8.out_ready = out_ready;
  assign b8.A = A;
  assign b8.B = B;
  assign b8.Bin = Bin;
  assign b32.in_valid = in_valid;
  assign b32.out_ready = out_ready;
  assign b32.A = A;
  assign b32.B = B;
  assign b32.Bin = Bin;
  assign b1.in_valid = in_valid;
  assign b1.out_ready = out_ready;
  assign b1.A = A;
  assign b1.B = B;
  assign b1.Bin = Bin;

  sub_serial_param #(.WIDTH(32), .CHUNK(16)) u16 (
    .clk(clk), .rst(rst), .bus(b16.slave));
  sub_serial_param #(.WIDTH(32), .CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .bus(b8.slave));
  sub_serial_param #(.WIDTH(32), .CHUNK(32)) u32 (
    .clk(clk), .rst(rst), .bus(b32.slave));
  sub_serial_param #(.WIDTH(32), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  logic [3:0]  ov;
  logic [3:0]  rdy;
  logic [3:0]  bo;
  logic [3:0]  of;
  logic [31:0] df [4];

  assign ov  = {b1.out_valid, b32.out_valid, b8.out_valid, b16.out_valid};
  assign rdy = {b1.in_ready, b32.in_ready, b8.in_ready, b16.in_ready};
  assign bo  = {b1.B_out, b32.B_out, b8.B_out, b16.B_out};
  assign df[0] = b16.Diff;
  assign df[1] = b8.Diff;
  assign df[2] = b32.Diff;
  assign df[3] = b1.Diff;
`ifdef SUB_SERIAL_OVF_EN
  assign of = {b1.OVF, b32.OVF, b8.OVF, b16.OVF};
`else
  assign of = 4'h0;
`endif

  logic [31:0] e_diff;
  logic        e_bo;
  logic        e_ovf;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain wide integer arithmetic.
  task automatic model(input logic [31:0] a, b, input logic bin);
    longint ur;
    longint sr;
    ur = longint'(a) - longint'(b) - longint'(bin);
    sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    e_diff = ur[31:0];
    e_bo   = (ur < 0);
    e_ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  task automatic start(input logic [31:0] a, b, input logic bin);
    @(negedge clk);
    A = a;
    B = b;
    Bin = bin;
    in_valid = 1'b1;
    out_ready = 1'b1;
    model(a, b, bin);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = $urandom;
    B = $urandom;
    Bin = 1'($urandom);
    check("acc_valid", 64'(ov), 64'h0);
    check("acc_ready", 64'(rdy), 64'h0);
  endtask

  task automatic collect();
    int lat [4];
    for (int k = 0; k < 4; k++) lat[k] = 0;
    for (int c = 1; c <= 40 && ov != 4'hf; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
        if (ov[k] && lat[k] == 0) lat[k] = c;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lat%0d", k), 64'(lat[k]), 64'(NCH[k]));
      check($sformatf("diff%0d", k), 64'(df[k]), 64'(e_diff));
      check($sformatf("bout%0d", k), 64'(bo[k]), 64'(e_bo));
`ifdef SUB_SERIAL_OVF_EN
      check($sformatf("ovf%0d", k), 64'(of[k]), 64'(e_ovf));
`endif
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(ov), 64'hf);
      check("hold_ready", 64'(rdy), 64'h0);
      for (int k = 0; k < 4; k++)
        check($sformatf("hold_diff%0d", k), 64'(df[k]), 64'(e_diff));
      check("hold_bout", 64'(bo), e_bo ? 64'hf : 64'h0);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_valid", 64'(ov), 64'h0);
    check("drain_ready", 64'(rdy), 64'hf);
  endtask

  task automatic op(input logic [31:0] a, b, input logic bin);
    start(a, b, bin);
    collect();
    drain();
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'hffff_ffff;
      2: v = 32'h8000_0000;
      3: v = 32'h7fff_ffff;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic stale;
    logic b2b;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    Bin = 1'b0;
    #12;
    check("rst_valid", 64'(ov), 64'h0);
    check("rst_ready", 64'(rdy), 64'hf);
    check("rst_bout", 64'(bo), 64'h0);
    check("rst_ovf", 64'(of), 64'h0);
    for (int k = 0; k < 4; k++)
      check($sformatf("rst_diff%0d", k), 64'(df[k]), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    op(32'd5, 32'd3, 1'b0);
    op(32'd0, 32'd1, 1'b0);
    op(32'h0001_0000, 32'd1, 1'b0);
    op(32'h0001_0000, 32'd0, 1'b1);
    op(32'h8000_0000, 32'd1, 1'b0);
    op(32'h7fff_ffff, 32'hffff_ffff, 1'b0);
    op(32'd0, 32'hffff_ffff, 1'b1);

    start(32'h1234_5678, 32'h8765_4321, 1'b1);
    collect();
    hold(5);
    start(32'hdead_beef, 32'h0bad_f00d, 1'b0);
    collect();
    drain();

    start(32'h0000_0009, 32'h0000_0004, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_valid", 64'(ov), 64'h0);
    check("t6_ready", 64'(rdy), 64'hf);
    for (int k = 0; k < 4; k++)
      check($sformatf("t6_diff%0d", k), 64'(df[k]), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      stale |= |ov;
    end
    check("t6_stale", 64'(stale), 64'h0);
    op(32'd5, 32'd3, 1'b0);

    b2b = 1'b0;
    repeat (40) begin
      start(pick(), pick(), 1'($urandom));
      collect();
      if ($urandom_range(0, 3) == 0) hold($urandom_range(1, 3));
      b2b = 1'($urandom);
      if (!b2b) drain();
    end
    if (b2b) drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
